// File: rtl/adld_pkg.sv
// Shared encodings for the button front end.
// State and repeat-phase enums used across the lab slice.
package adld_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  typedef enum logic {
    PH_DELAY  = 1'b0,
    PH_PERIOD = 1'b1
  } phase_t;

endpackage

// File: rtl/sync_ff.sv
// Reset-to-0 flop chain for bringing asynchronous inputs
// into the clk domain.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/btn_step_gen.sv
// Button front end: sync, debounce, press/repeat step pulses
// and a release pulse for the counter labs.
module btn_step_gen
  import adld_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn_raw,
  output logic o_btn_level,
  output logic o_step,
  output logic o_release
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  state_t          r_state, w_state_nx;
  phase_t          r_phase, w_phase_nx;
  logic [DW-1:0]   r_db_cnt, w_db_nx;
  logic [RW-1:0]   r_rep_cnt, w_rep_nx;
  logic [RW-1:0]   w_rep_last;
  logic            r_level, w_level_nx;
  logic            r_step, w_step_nx;
  logic            r_release, w_rel_nx;
  logic            w_sync;
  logic            w_db_done;
  logic            w_rep_on;
  logic            w_rep_fire;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (i_btn_raw),
    .o_q   (w_sync)
  );

  assign w_db_done  = (r_db_cnt == DB_LAST);
  assign w_rep_last = (r_phase == PH_DELAY) ? RD_LAST : RP_LAST;
  // Level is still 1 in REL_DB, so repeats keep running there.
  assign w_rep_on   = (REPEAT_EN != 0) &&
                      ((r_state == HELD) || (r_state == REL_DB));
  assign w_rep_fire = w_rep_on && (r_rep_cnt == w_rep_last);

  always_comb begin
    w_state_nx = r_state;
    w_db_nx    = r_db_cnt;
    w_rep_nx   = r_rep_cnt;
    w_phase_nx = r_phase;
    w_level_nx = r_level;
    w_step_nx  = w_rep_fire;
    w_rel_nx   = 1'b0;

    if (w_rep_fire) begin
      w_rep_nx   = '0;
      w_phase_nx = PH_PERIOD;
    end else if (w_rep_on) begin
      w_rep_nx = r_rep_cnt + 1'b1;
    end

    unique case (r_state)
      IDLE: begin
        if (w_sync) begin
          w_state_nx = PRESS_DB;
          w_db_nx    = r_db_cnt + 1'b1;
        end
      end
      PRESS_DB: begin
        if (!w_sync) begin
          w_state_nx = IDLE;
          w_db_nx    = '0;
        end else if (w_db_done) begin
          w_state_nx = HELD;
          w_db_nx    = '0;
          w_level_nx = 1'b1;
          w_step_nx  = 1'b1;
          w_rep_nx   = '0;
          w_phase_nx = PH_DELAY;
        end else begin
          w_db_nx = r_db_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!w_sync) begin
          w_state_nx = REL_DB;
          w_db_nx    = r_db_cnt + 1'b1;
        end
      end
      REL_DB: begin
        if (w_sync) begin
          w_state_nx = HELD;
          w_db_nx    = '0;
        end else if (w_db_done) begin
          // Release beats a coincident repeat step.
          w_state_nx = IDLE;
          w_db_nx    = '0;
          w_level_nx = 1'b0;
          w_rel_nx   = 1'b1;
          w_step_nx  = 1'b0;
          w_rep_nx   = '0;
          w_phase_nx = PH_DELAY;
        end else begin
          w_db_nx = r_db_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_phase   <= PH_DELAY;
      r_db_cnt  <= '0;
      r_rep_cnt <= '0;
      r_level   <= 1'b0;
      r_step    <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_phase   <= w_phase_nx;
      r_db_cnt  <= w_db_nx;
      r_rep_cnt <= w_rep_nx;
      r_level   <= w_level_nx;
      r_step    <= w_step_nx;
      r_release <= w_rel_nx;
    end
  end

  assign o_btn_level = r_level;
  assign o_step      = r_step;
  assign o_release   = r_release;

endmodule
